// File: rtl/prio_arb_encoder.sv
// Registered N-input priority arbiter/encoder with valid/ready output.
// Fixed priority (highest index wins) or round-robin, selected by RR.
module prio_arb_encoder #(
    parameter int unsigned N  = 10,
    parameter int unsigned W  = 4,
    parameter int unsigned RR = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] grant,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    if (N < 2 || N > 64) begin : g_bad_n
        $error("prio_arb_encoder: N=%0d outside 2..64", N);
    end
    if ((64'd1 << W) < 64'(N)) begin : g_bad_w
        $error("prio_arb_encoder: W=%0d too narrow for N=%0d", W, N);
    end

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] idx_q, idx_d;
    logic [N-1:0] grant_q, grant_d;
    logic [W-1:0] ptr_q, ptr_d;

    logic         xfer;
    logic         has_req;
    logic [W-1:0] ptr_eff;
    logic [N-1:0] le_mask;
    logic [N-1:0] req_lo;
    logic [W-1:0] win_idx;
    logic         load;
    logic         clear;

    // Index of the highest set bit (0 when none set).
    function automatic logic [W-1:0] top_idx(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (v[i]) r = W'(i);
        end
        return r;
    endfunction

    // Winner selection against the pointer as it stands after this edge's transfer.
    // Round-robin order ptr, ptr-1, ..., 0, N-1, ..., ptr+1 is the highest request
    // at or below ptr, falling back to the highest request overall.
    always_comb begin
        xfer    = (state_q == GRANT) && out_ready;
        has_req = (req != '0);
        ptr_eff = ptr_q;
        if (xfer) begin
            ptr_eff = (idx_q == '0) ? W'(N - 1) : idx_q - W'(1);
        end
        le_mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            le_mask[i] = (i <= 32'(ptr_eff));
        end
        req_lo = req & le_mask;
        if (RR != 0 && req_lo != '0) begin
            win_idx = top_idx(req_lo);
        end else begin
            win_idx = top_idx(req);
        end
    end

    // Next-state, latched grant and pointer update.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        load    = 1'b0;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && has_req) load = 1'b1;
            end
            GRANT: begin
                if (xfer) begin
                    ptr_d = ptr_eff;
                    if (en && has_req) load = 1'b1;
                    else               clear = 1'b1;
                end else if (!en) begin
                    clear = 1'b1;
                end
            end
        endcase
        if (load) begin
            state_d = GRANT;
            idx_d   = win_idx;
            for (int unsigned i = 0; i < N; i++) begin
                grant_d[i] = (win_idx == W'(i));
            end
        end else if (clear) begin
            state_d = IDLE;
            idx_d   = '0;
            grant_d = '0;
        end
    end

    // State, output and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            grant_q <= '0;
            ptr_q   <= W'(N - 1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_idx   = idx_q;
    assign grant     = grant_q;
    assign out_valid = (state_q == GRANT);
    assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_prio_arb_encoder.sv
// Scoreboard bench for prio_arb_encoder over several N/W/RR configurations.
module tb_prio_arb_encoder;

    localparam int unsigned NC = 6;
    localparam int unsigned CN [NC] = '{10, 10, 16, 3, 16, 3};
    localparam int unsigned CW [NC] = '{4, 4, 4, 2, 4, 2};
    localparam int unsigned CR [NC] = '{0, 1, 1, 0, 0, 1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en;
    logic [63:0] req_all;
    logic        out_ready;

    logic [NC-1:0] dv;
    logic [NC-1:0] db;
    logic [5:0]    di [NC];
    logic [63:0]   dg [NC];

    typedef struct packed {
        logic [NC-1:0]       v;
        logic [NC-1:0][5:0]  idx;
        logic [NC-1:0][63:0] gnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    for (genvar c = 0; c < NC; c++) begin : g_dut
        localparam int unsigned NN  = CN[c];
        localparam int unsigned WW  = CW[c];
        localparam int unsigned RRV = CR[c];
        logic [WW-1:0] idx_w;
        logic [NN-1:0] gnt_w;
        logic          v_w;
        logic          b_w;
        prio_arb_encoder #(.N(NN), .W(WW), .RR(RRV)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .req       (req_all[NN-1:0]),
            .out_idx   (idx_w),
            .grant     (gnt_w),
            .out_valid (v_w),
            .out_ready (out_ready),
            .busy      (b_w)
        );
        assign dv[c] = v_w;
        assign db[c] = b_w;
        assign di[c] = 6'(idx_w);
        assign dg[c] = 64'(gnt_w);
    end

    // Reference: winner by walking the search order directly.
    function automatic int pick(input logic [63:0] r, input int n, input int rr, input int p);
        if (rr == 0) begin
            for (int j = n - 1; j >= 0; j--) if (r[j]) return j;
        end else begin
            for (int k = 0; k < n; k++) begin
                int j;
                j = (p - k + n) % n;
                if (r[j]) return j;
            end
        end
        return -1;
    endfunction

    // Reference model: one expectation per clock edge (or on async reset).
    initial begin
        bit   pend [NC];
        int   pidx [NC];
        int   ptr  [NC];
        logic last_rst;
        exp_t e;
        last_rst = 1'b0;
        for (int c = 0; c < NC; c++) begin
            pend[c] = 0; pidx[c] = 0; ptr[c] = CN[c] - 1;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            e = '0;
            if (!rst_n) begin
                for (int c = 0; c < NC; c++) begin
                    pend[c] = 0; pidx[c] = 0; ptr[c] = CN[c] - 1;
                end
                if (last_rst) begin
                    q.delete();
                    q.push_back(e);
                    if (clk) q.push_back(e);
                end else begin
                    q.push_back(e);
                end
            end else begin
                for (int c = 0; c < NC; c++) begin
                    int          n;
                    logic [63:0] r;
                    bit          xf;
                    n  = CN[c];
                    r  = (n == 64) ? req_all : (req_all & ((64'd1 << n) - 64'd1));
                    xf = pend[c] && out_ready;
                    if (xf) ptr[c] = (pidx[c] == 0) ? n - 1 : pidx[c] - 1;
                    if (!pend[c] || xf) begin
                        if (en && r != 0) begin
                            pidx[c] = pick(r, n, CR[c], ptr[c]);
                            pend[c] = 1;
                        end else begin
                            pend[c] = 0;
                        end
                    end else if (!en) begin
                        pend[c] = 0;
                    end
                    if (pend[c]) begin
                        e.v[c]   = 1'b1;
                        e.idx[c] = 6'(pidx[c]);
                        e.gnt[c] = 64'd1 << pidx[c];
                    end
                end
                q.push_back(e);
            end
            last_rst = rst_n;
        end
    end

    task automatic chk(input string nm, input int c, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL cfg%0d %s got=%0h want=%0h t=%0t", c, nm, got, want, $time);
        end
    endtask

    // Monitor: compares DUT outputs away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty got=0 want=1 t=%0t", $time);
            end else begin
                e = q.pop_front();
                for (int c = 0; c < NC; c++) begin
                    chk("out_valid", c, 64'(dv[c]), 64'(e.v[c]));
                    chk("busy",      c, 64'(db[c]), 64'(e.v[c]));
                    chk("out_idx",   c, 64'(di[c]), 64'(e.idx[c]));
                    chk("grant",     c, dg[c],      e.gnt[c]);
                end
            end
        end
    end

    task automatic cyc(input logic e, input logic [63:0] r, input logic rd);
        en        = e;
        req_all   = r;
        out_ready = rd;
        @(posedge clk);
        #2;
    endtask

    // Stimulus.
    initial begin
        logic [63:0] r;
        en = 1'b0; req_all = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Fixed priority, stall with changing req, then back-to-back.
        cyc(1'b1, 64'h205, 1'b0);
        repeat (3) cyc(1'b1, 64'h001, 1'b0);
        repeat (3) cyc(1'b1, 64'h001, 1'b1);
        cyc(1'b0, 64'h000, 1'b1);

        // Round-robin fairness with all lines requesting.
        repeat (25) cyc(1'b1, 64'h3FF, 1'b1);
        repeat (20) cyc(1'b1, '1, 1'b1);

        // Wrap between the two extreme lines.
        repeat (6) cyc(1'b1, 64'h201, 1'b1);
        cyc(1'b0, 64'h000, 1'b0);

        // Abort a pending grant of index 5, then re-enable.
        cyc(1'b1, 64'h020, 1'b0);
        cyc(1'b1, 64'h020, 1'b0);
        cyc(1'b0, 64'h020, 1'b0);
        repeat (4) cyc(1'b1, 64'h3FF, 1'b1);

        // Enable dropped in the same cycle as a transfer.
        cyc(1'b1, 64'h3FF, 1'b0);
        cyc(1'b0, 64'h3FF, 1'b1);
        cyc(1'b0, 64'h3FF, 1'b0);

        // No requests: nothing is granted.
        repeat (6) cyc(1'b1, 64'h000, 1'b1);

        // Asynchronous reset in the middle of a grant.
        cyc(1'b1, 64'h3FF, 1'b0);
        cyc(1'b1, 64'h3FF, 1'b0);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (12) cyc(1'b1, 64'h3FF, 1'b1);

        // Randomized traffic.
        repeat (3000) begin
            r = {$urandom, $urandom};
            case ($urandom % 4)
                0: r = r & {$urandom, $urandom} & {$urandom, $urandom};
                1: r = 64'd1 << ($urandom % 64);
                2: r = ($urandom % 3 == 0) ? 64'h0 : r;
                default: ;
            endcase
            cyc(($urandom % 8) != 0, r, ($urandom % 4) != 0);
        end
        repeat (3) cyc(1'b0, 64'h0, 1'b1);
        @(negedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prio_arb_encoder.md
Name: prio_arb_encoder

Overview:
- Parametrised, registered successor to the combinational 10-to-4 priority encoder.
- Takes N request lines and produces the binary index and one-hot grant of the winner, with a valid/ready output handshake.
- Selectable fixed-priority (highest index wins) or round-robin arbitration.
- Sits between request sources (interrupt/event lines) and a consumer that accepts one index per transfer.

Parameters:
- N, 10, number of request lines (2..64).
- W, 4, index width; must satisfy 2^W >= N (elaboration-time check, $error on violation).
- RR, 0, 0 = fixed priority with highest index winning; 1 = round-robin.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  enable; low aborts a pending grant and blocks new grants.
- req  input  N  request lines, level-sensitive, any number set.
- out_idx  output  W  binary index of the granted line; 0 when out_valid=0.
- grant  output  N  one-hot of the granted line; all zero when out_valid=0.
- out_valid  output  1  index/grant valid.
- out_ready  input  1  consumer accepts when out_valid and out_ready are both high on a rising edge (transfer).
- busy  output  1  high in GRANT state (equal to out_valid).

Behaviour:
- Reset: out_idx=0, grant=0, out_valid=0, busy=0, state=IDLE, rr pointer ptr=N-1. Clears immediately on rst_n low, independent of clk.
- All outputs are registered; there is no combinational path from req, en or out_ready to any output.
- States:
  - IDLE: if en=1 and req!=0 at a clock edge, latch the winner and go to GRANT. out_valid rises the cycle after req is sampled (latency 1). Otherwise stay in IDLE.
  - GRANT: out_idx and grant are held stable while out_valid=1 and out_ready=0, even if req changes or the granted line drops (the grant is latched).
    - Transfer with en=1 and req!=0 in the same cycle: load the next winner at that edge; out_valid stays 1 (back-to-back, one index per cycle).
    - Transfer otherwise: go to IDLE; outputs clear next cycle.
    - en=0 without a transfer: abort. Go to IDLE, outputs clear next cycle, ptr unchanged.
    - en=0 with a transfer in the same cycle: the transfer completes and ptr updates; no new load; go to IDLE.
- Winner selection:
  - RR=0: highest set index in req. Identical priority to the original 10-to-4 encoder.
  - RR=1: search order is ptr, ptr-1, ..., 0, N-1, ..., ptr+1; the first set bit wins.
  - On every transfer of index g, ptr <= g-1, or N-1 when g=0 (wrap). The granted line becomes lowest priority.
  - ptr changes only on a transfer, never on load or abort.
  - Because ptr resets to N-1, the first round-robin decision equals the fixed-priority decision.
- Load uses the req value sampled at the load edge. The winner is computed against the ptr value after the same-edge update (back-to-back loads must already respect the new ptr).
- Invariants:
  - grant is one-hot or zero.
  - grant[out_idx]=1 whenever out_valid=1.
  - out_idx < N always.
- Request bits for indices >= N do not exist; no X propagation from unused index codes.

Test Plan:
- Reset: assert rst_n=0 mid-GRANT (out_idx=9) -> out_valid=0, out_idx=0, grant=0 before the next edge. After release with RR=1 and req=10'h3FF, the first index is 9.
- Fixed priority and stall: RR=0, en=1, req=10'b1000000101 -> next cycle out_valid=1, out_idx=9, grant=10'b1000000000. Hold out_ready=0 for 3 cycles while req changes to 10'b0000000001 -> outputs unchanged. Then out_ready=1 -> next cycle out_idx=0, out_valid=1 (back-to-back).
- Round-robin fairness: RR=1, req=10'h3FF held, out_ready=1 continuously -> out_idx sequence 9,8,7,6,5,4,3,2,1,0,9,... with out_valid=1 every cycle after the first.
- Round-robin wrap: RR=1, req=10'b1000000001, out_ready=1 -> 9,0,9,0. ptr goes 8, then N-1, then 8.
- Enable abort: pending grant of index 5 with out_ready=0, drop en -> next cycle out_valid=0, out_idx=0, grant=0. Re-assert en with req=10'h3FF (RR=1) -> the next grant is 9, showing ptr was unchanged by the abort.
- Empty and parameter sweep: req=0 with en=1 -> out_valid stays 0 indefinitely. Repeat the fixed and round-robin scenarios with N=16, W=4 and N=3, W=2; out_idx matches a reference model every cycle.
